// File: rtl/ble_exmem_arb.sv
// N-channel arbiter bridging internal BLE masters onto the single ex_mem_* port.
// Round-robin or fixed-priority grant, per-transaction timeout with error flag.
module ble_exmem_arb #(
  parameter int unsigned NCH    = 3,
  parameter int unsigned AW     = 23,
  parameter int unsigned DW     = 32,
  parameter int unsigned TO_CYC = 255,
  parameter int unsigned TO_W   = 8
) (
  input  logic                      bsb_clk,
  input  logic                      ble_rst_,
  input  logic                      prio_mode,
  input  logic [NCH-1:0]            ch_req,
  input  logic [NCH*(DW/8)-1:0]     ch_we,
  input  logic [NCH*AW-1:0]         ch_adr,
  input  logic [NCH*DW-1:0]         ch_wdat,
  output logic [NCH-1:0]            ch_ack,
  output logic [NCH-1:0]            ch_err,
  output logic [DW-1:0]             ch_rdat,
  output logic                      ex_mem_req,
  output logic [DW/8-1:0]           ex_mem_we,
  output logic [AW-1:0]             ex_mem_adr,
  output logic [DW-1:0]             ex_mem_wdat,
  input  logic [DW-1:0]             ex_mem_rdat,
  input  logic                      ex_mem_ack
);

  localparam int unsigned BW    = DW / 8;
  localparam int unsigned PW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int          NCH_I = int'(NCH);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TO_CYC == 0) ? 0 : TO_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   gnt;
  logic [TO_W-1:0] cnt;

  logic            any_req;
  logic [PW-1:0]   sel;
  logic [PW-1:0]   ptr_nxt;
  logic [BW-1:0]   sel_we;
  logic [AW-1:0]   sel_adr;
  logic [DW-1:0]   sel_wdat;
  int              idx;

  // Grant search: upward from ptr (round-robin) or from channel 0 (fixed).
  always_comb begin
    any_req = 1'b0;
    sel     = '0;
    idx     = 0;
    for (int k = 0; k < NCH_I; k++) begin
      idx = prio_mode ? k : (int'(ptr) + k) % NCH_I;
      if (!any_req && ch_req[PW'(idx)]) begin
        any_req = 1'b1;
        sel     = PW'(idx);
      end
    end
  end

  // Payload mux for the selected channel.
  always_comb begin
    sel_we   = '0;
    sel_adr  = '0;
    sel_wdat = '0;
    for (int i = 0; i < NCH_I; i++) begin
      if (sel == PW'(i)) begin
        sel_we   = ch_we[i*BW +: BW];
        sel_adr  = ch_adr[i*AW +: AW];
        sel_wdat = ch_wdat[i*DW +: DW];
      end
    end
  end

  assign ptr_nxt = (sel == PW'(NCH - 1)) ? '0 : PW'(sel + 1'b1);

  always_ff @(posedge bsb_clk or negedge ble_rst_) begin
    if (!ble_rst_) begin
      state       <= S_IDLE;
      ptr         <= '0;
      gnt         <= '0;
      cnt         <= '0;
      ex_mem_req  <= 1'b0;
      ex_mem_we   <= '0;
      ex_mem_adr  <= '0;
      ex_mem_wdat <= '0;
      ch_ack      <= '0;
      ch_err      <= '0;
      ch_rdat     <= '0;
    end else begin
      ch_ack <= '0;
      ch_err <= '0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            gnt         <= sel;
            ex_mem_we   <= sel_we;
            ex_mem_adr  <= sel_adr;
            ex_mem_wdat <= sel_wdat;
            ex_mem_req  <= 1'b1;
            cnt         <= '0;
            if (!prio_mode) ptr <= ptr_nxt;
            state       <= S_BUSY;
          end
        end
        S_BUSY: begin
          // A memory ack in the timeout cycle still completes without error.
          if (ex_mem_ack) begin
            ch_rdat    <= ex_mem_rdat;
            ex_mem_req <= 1'b0;
            ch_ack     <= NCH'(1) << gnt;
            state      <= S_RESP;
          end else if ((TO_CYC != 0) && (cnt == TO_LAST)) begin
            ch_rdat    <= '0;
            ex_mem_req <= 1'b0;
            ch_ack     <= NCH'(1) << gnt;
            ch_err     <= NCH'(1) << gnt;
            state      <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ble_exmem_arb.sv
// Self-checking bench for ble_exmem_arb: directed scenarios plus randomized
// traffic checked against a grant/memory reference model.
module tb_ble_exmem_arb;

  localparam int NCH    = 3;
  localparam int AW     = 23;
  localparam int DW     = 32;
  localparam int BW     = DW / 8;
  localparam int TO_CYC = 4;
  localparam int TO_W   = 8;

  logic                  bsb_clk   = 1'b0;
  logic                  ble_rst_  = 1'b0;
  logic                  prio_mode = 1'b0;
  logic [NCH-1:0]        ch_req    = '0;
  logic [NCH*BW-1:0]     ch_we;
  logic [NCH*AW-1:0]     ch_adr;
  logic [NCH*DW-1:0]     ch_wdat;
  logic [NCH-1:0]        ch_ack;
  logic [NCH-1:0]        ch_err;
  logic [DW-1:0]         ch_rdat;
  logic                  ex_mem_req;
  logic [BW-1:0]         ex_mem_we;
  logic [AW-1:0]         ex_mem_adr;
  logic [DW-1:0]         ex_mem_wdat;
  logic [DW-1:0]         ex_mem_rdat = '0;
  logic                  ex_mem_ack  = 1'b0;

  logic [BW-1:0] f_we   [NCH];
  logic [AW-1:0] f_adr  [NCH];
  logic [DW-1:0] f_wdat [NCH];

  int checks = 0;
  int errors = 0;
  int p_model = 0;

  logic [DW-1:0] dev_mem [int];
  logic [DW-1:0] ref_mem [int];

  ble_exmem_arb #(
    .NCH(NCH), .AW(AW), .DW(DW), .TO_CYC(TO_CYC), .TO_W(TO_W)
  ) dut (
    .bsb_clk     (bsb_clk),
    .ble_rst_    (ble_rst_),
    .prio_mode   (prio_mode),
    .ch_req      (ch_req),
    .ch_we       (ch_we),
    .ch_adr      (ch_adr),
    .ch_wdat     (ch_wdat),
    .ch_ack      (ch_ack),
    .ch_err      (ch_err),
    .ch_rdat     (ch_rdat),
    .ex_mem_req  (ex_mem_req),
    .ex_mem_we   (ex_mem_we),
    .ex_mem_adr  (ex_mem_adr),
    .ex_mem_wdat (ex_mem_wdat),
    .ex_mem_rdat (ex_mem_rdat),
    .ex_mem_ack  (ex_mem_ack)
  );

  always #5 bsb_clk = ~bsb_clk;

  always_comb begin
    ch_we   = '0;
    ch_adr  = '0;
    ch_wdat = '0;
    for (int i = 0; i < NCH; i++) begin
      ch_we[i*BW +: BW]   = f_we[i];
      ch_adr[i*AW +: AW]  = f_adr[i];
      ch_wdat[i*DW +: DW] = f_wdat[i];
    end
  end

  // ---------------- reference model ----------------
  function automatic int model_grant(input logic [NCH-1:0] req, input logic mode);
    if (mode) begin
      for (int i = 0; i < NCH; i++) if (req[i]) return i;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        int i = (p_model + k) % NCH;
        if (req[i]) return i;
      end
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return {a[7:0], 1'b0, a} ^ 32'h3C3C_0000;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] w,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = o;
    for (int b = 0; b < BW; b++) if (be[b]) r[b*8 +: 8] = w[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] dev_read(input logic [AW-1:0] a);
    return dev_mem.exists(int'(a)) ? dev_mem[int'(a)] : init_val(a);
  endfunction

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
  endfunction

  task automatic apply_reset();
    ble_rst_   = 1'b0;
    ch_req     = '0;
    ex_mem_ack = 1'b0;
    repeat (2) @(negedge bsb_clk);
    ble_rst_ = 1'b1;
    @(negedge bsb_clk);
    p_model = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    ble_rst_ = 1'b0;
    #1;
    checks++;
    if (ex_mem_req !== 1'b0) begin
      errors++; $display("FAIL reset_req_async got=%b exp=0", ex_mem_req);
    end
    apply_reset();
    checks++;
    if ({ex_mem_req, ex_mem_we, ex_mem_adr, ex_mem_wdat, ch_ack, ch_err, ch_rdat} !== '0) begin
      errors++;
      $display("FAIL reset_values got req=%b we=%h adr=%h wdat=%h ack=%b err=%b rdat=%h exp all zero",
               ex_mem_req, ex_mem_we, ex_mem_adr, ex_mem_wdat, ch_ack, ch_err, ch_rdat);
    end
  endtask

  task automatic test_single_read();
    prio_mode = 1'b0;
    f_adr[1]  = 23'h00_1234;
    f_we[1]   = '0;
    f_wdat[1] = 32'h1111_2222;
    ch_req    = 3'b010;
    void'(model_grant(3'b010, 1'b0));
    p_model = 2;
    @(negedge bsb_clk);
    checks++;
    if (ex_mem_req !== 1'b1 || ex_mem_adr !== 23'h00_1234 || ex_mem_we !== '0) begin
      errors++; $display("FAIL single_issue got req=%b adr=%h we=%h exp req=1 adr=001234 we=0",
                         ex_mem_req, ex_mem_adr, ex_mem_we);
    end
    @(negedge bsb_clk);
    @(negedge bsb_clk);
    ex_mem_ack  = 1'b1;
    ex_mem_rdat = 32'hDEAD_BEEF;
    @(negedge bsb_clk);
    ex_mem_ack = 1'b0;
    checks++;
    if (ch_ack !== 3'b010 || ch_err !== 3'b000 || ch_rdat !== 32'hDEAD_BEEF || ex_mem_req !== 1'b0) begin
      errors++; $display("FAIL single_resp got ack=%b err=%b rdat=%h req=%b exp ack=010 err=000 rdat=deadbeef req=0",
                         ch_ack, ch_err, ch_rdat, ex_mem_req);
    end
    ch_req = '0;
    @(negedge bsb_clk);
    checks++;
    if (ch_ack !== 3'b000) begin
      errors++; $display("FAIL single_ack_pulse got=%b exp=000", ch_ack);
    end
  endtask

  task automatic test_rr_fairness();
    int cnt [NCH];
    int exp_g;
    int obs;
    apply_reset();
    prio_mode = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      cnt[i]    = 0;
      f_adr[i]  = AW'(32'h100 * (i + 1));
      f_we[i]   = '0;
      f_wdat[i] = '0;
    end
    ch_req = 3'b111;
    for (int t = 0; t < 6; t++) begin
      for (int w = 0; w < 10 && !ex_mem_req; w++) @(negedge bsb_clk);
      checks++;
      if (ex_mem_req !== 1'b1) begin
        errors++; $display("FAIL rr_wait_req t=%0d got=%b exp=1", t, ex_mem_req);
      end
      exp_g = model_grant(3'b111, 1'b0);
      p_model = (exp_g + 1) % NCH;
      checks++;
      if (ex_mem_adr !== f_adr[exp_g]) begin
        errors++; $display("FAIL rr_adr t=%0d got=%h exp=%h", t, ex_mem_adr, f_adr[exp_g]);
      end
      ex_mem_ack  = 1'b1;
      ex_mem_rdat = DW'(32'hC0DE_0000 + t);
      @(negedge bsb_clk);
      ex_mem_ack = 1'b0;
      obs = -1;
      for (int i = 0; i < NCH; i++) if (ch_ack[i]) obs = i;
      if (obs >= 0) cnt[obs]++;
      checks++;
      if (obs != t % NCH || ch_rdat !== DW'(32'hC0DE_0000 + t)) begin
        errors++; $display("FAIL rr_order t=%0d got ch=%0d rdat=%h exp ch=%0d rdat=%h",
                           t, obs, ch_rdat, t % NCH, DW'(32'hC0DE_0000 + t));
      end
    end
    ch_req = '0;
    @(negedge bsb_clk);
    for (int i = 0; i < NCH; i++) begin
      checks++;
      if (cnt[i] != 2) begin
        errors++; $display("FAIL rr_share ch=%0d got=%0d exp=2", i, cnt[i]);
      end
    end
  endtask

  task automatic test_fixed_priority();
    logic [DW-1:0] rd;
    prio_mode = 1'b1;
    ch_req = 3'b110;
    @(negedge bsb_clk);
    checks++;
    if (ex_mem_req !== 1'b1 || ex_mem_adr !== f_adr[1]) begin
      errors++; $display("FAIL fixed_first got req=%b adr=%h exp req=1 adr=%h", ex_mem_req, ex_mem_adr, f_adr[1]);
    end
    ch_req = 3'b111;
    @(negedge bsb_clk);
    rd = 32'h0BAD_F00D;
    ex_mem_ack = 1'b1; ex_mem_rdat = rd;
    @(negedge bsb_clk);
    ex_mem_ack = 1'b0;
    checks++;
    if (ch_ack !== 3'b010 || ch_rdat !== rd) begin
      errors++; $display("FAIL fixed_ch1_done got ack=%b rdat=%h exp ack=010 rdat=%h", ch_ack, ch_rdat, rd);
    end
    ch_req = 3'b101;
    @(negedge bsb_clk);
    @(negedge bsb_clk);
    checks++;
    if (ex_mem_req !== 1'b1 || ex_mem_adr !== f_adr[0]) begin
      errors++; $display("FAIL fixed_second got req=%b adr=%h exp req=1 adr=%h", ex_mem_req, ex_mem_adr, f_adr[0]);
    end
    ex_mem_ack = 1'b1;
    @(negedge bsb_clk);
    ex_mem_ack = 1'b0;
    checks++;
    if (ch_ack !== 3'b001) begin
      errors++; $display("FAIL fixed_ch0_done got ack=%b exp=001", ch_ack);
    end
    ch_req = 3'b100;
    @(negedge bsb_clk);
    @(negedge bsb_clk);
    checks++;
    if (ex_mem_req !== 1'b1 || ex_mem_adr !== f_adr[2]) begin
      errors++; $display("FAIL fixed_third got req=%b adr=%h exp req=1 adr=%h", ex_mem_req, ex_mem_adr, f_adr[2]);
    end
    ex_mem_ack = 1'b1;
    @(negedge bsb_clk);
    ex_mem_ack = 1'b0;
    checks++;
    if (ch_ack !== 3'b100) begin
      errors++; $display("FAIL fixed_ch2_done got ack=%b exp=100", ch_ack);
    end
    ch_req = '0;
    @(negedge bsb_clk);
  endtask

  task automatic test_timeout();
    int hi;
    int exp_g;
    prio_mode = 1'b0;
    ch_req = 3'b001;
    exp_g = model_grant(3'b001, 1'b0);
    p_model = (exp_g + 1) % NCH;
    @(negedge bsb_clk);
    hi = 0;
    for (int c = 0; c < 20 && ex_mem_req; c++) begin
      hi++;
      @(negedge bsb_clk);
    end
    checks++;
    if (hi != TO_CYC) begin
      errors++; $display("FAIL timeout_req_cycles got=%0d exp=%0d", hi, TO_CYC);
    end
    checks++;
    if (ch_ack !== 3'b001 || ch_err !== 3'b001 || ch_rdat !== '0) begin
      errors++; $display("FAIL timeout_resp got ack=%b err=%b rdat=%h exp ack=001 err=001 rdat=0",
                         ch_ack, ch_err, ch_rdat);
    end
    ch_req = '0;
    @(negedge bsb_clk);
    @(negedge bsb_clk);
    ex_mem_ack = 1'b1; ex_mem_rdat = 32'hFFFF_FFFF;
    @(negedge bsb_clk);
    ex_mem_ack = 1'b0;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (ch_ack !== '0 || ch_err !== '0 || ex_mem_req !== 1'b0) begin
        errors++; $display("FAIL late_ack c=%0d got ack=%b err=%b req=%b exp all 0", c, ch_ack, ch_err, ex_mem_req);
      end
      @(negedge bsb_clk);
    end
  endtask

  task automatic test_byte_write();
    int exp_g;
    prio_mode = 1'b0;
    f_we[2]   = 4'b0011;
    f_wdat[2] = 32'hA5A5_5A5A;
    f_adr[2]  = 23'h00_0300;
    ch_req    = 3'b100;
    exp_g = model_grant(3'b100, 1'b0);
    p_model = (exp_g + 1) % NCH;
    for (int c = 0; c < 4; c++) begin
      @(negedge bsb_clk);
      checks++;
      if (ex_mem_req !== 1'b1 || ex_mem_we !== 4'b0011 || ex_mem_wdat !== 32'hA5A5_5A5A ||
          ex_mem_adr !== 23'h00_0300) begin
        errors++; $display("FAIL bytewr_hold c=%0d got req=%b we=%b wdat=%h adr=%h exp req=1 we=0011 wdat=a5a55a5a adr=000300",
                           c, ex_mem_req, ex_mem_we, ex_mem_wdat, ex_mem_adr);
      end
    end
    ex_mem_ack = 1'b1;
    @(negedge bsb_clk);
    ex_mem_ack = 1'b0;
    checks++;
    if (ch_ack !== 3'b100 || ch_err !== 3'b000) begin
      errors++; $display("FAIL bytewr_resp got ack=%b err=%b exp ack=100 err=000", ch_ack, ch_err);
    end
    ch_req = '0;
    @(negedge bsb_clk);
  endtask

  task automatic test_reset_mid_busy();
    int exp_g;
    prio_mode = 1'b0;
    ch_req = 3'b010;
    @(negedge bsb_clk);
    @(negedge bsb_clk);
    #2 ble_rst_ = 1'b0;
    #1;
    checks++;
    if (ex_mem_req !== 1'b0) begin
      errors++; $display("FAIL rst_mid_req got=%b exp=0", ex_mem_req);
    end
    ch_req = '0;
    @(negedge bsb_clk);
    ble_rst_ = 1'b1;
    p_model = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge bsb_clk);
      checks++;
      if (ch_ack !== '0 || ex_mem_req !== 1'b0) begin
        errors++; $display("FAIL rst_mid_noack c=%0d got ack=%b req=%b exp ack=000 req=0", c, ch_ack, ex_mem_req);
      end
    end
    ch_req = 3'b110;
    exp_g = model_grant(3'b110, 1'b0);
    p_model = (exp_g + 1) % NCH;
    @(negedge bsb_clk);
    checks++;
    if (ex_mem_adr !== f_adr[exp_g]) begin
      errors++; $display("FAIL rst_mid_ptr got adr=%h exp adr=%h (ch %0d)", ex_mem_adr, f_adr[exp_g], exp_g);
    end
    ex_mem_ack = 1'b1;
    @(negedge bsb_clk);
    ex_mem_ack = 1'b0;
    checks++;
    if (ch_ack !== NCH'(1) << exp_g) begin
      errors++; $display("FAIL rst_mid_after got ack=%b exp=%b", ch_ack, NCH'(1) << exp_g);
    end
    ch_req = '0;
    @(negedge bsb_clk);
  endtask

  task automatic test_random();
    logic [NCH-1:0] req;
    logic           mode;
    int             lat, exp_g, hi;
    bit             drop, done, tmo, wr;
    logic [DW-1:0]  exp_rd;
    for (int it = 0; it < 60; it++) begin
      mode = 1'($urandom_range(0, 1));
      for (int i = 0; i < NCH; i++) begin
        f_adr[i]  = AW'($urandom_range(0, 15));
        f_we[i]   = ($urandom_range(0, 1) == 1) ? BW'($urandom) : '0;
        f_wdat[i] = $urandom;
      end
      req  = NCH'($urandom_range(1, (1 << NCH) - 1));
      lat  = $urandom_range(0, 5);
      drop = ($urandom_range(0, 3) == 0);
      prio_mode = mode;
      ch_req    = req;
      exp_g = model_grant(req, mode);
      if (!mode) p_model = (exp_g + 1) % NCH;
      tmo = (lat >= TO_CYC);
      wr  = (f_we[exp_g] != '0);
      exp_rd = tmo ? '0 : ref_read(f_adr[exp_g]);
      if (!tmo && wr) ref_mem[int'(f_adr[exp_g])] = merge(ref_read(f_adr[exp_g]), f_wdat[exp_g], f_we[exp_g]);
      @(negedge bsb_clk);
      checks++;
      if (ex_mem_req !== 1'b1 || {ex_mem_we, ex_mem_adr, ex_mem_wdat} !== {f_we[exp_g], f_adr[exp_g], f_wdat[exp_g]}) begin
        errors++; $display("FAIL rnd_issue it=%0d got req=%b we=%h adr=%h wdat=%h exp ch=%0d we=%h adr=%h wdat=%h",
                           it, ex_mem_req, ex_mem_we, ex_mem_adr, ex_mem_wdat, exp_g, f_we[exp_g], f_adr[exp_g], f_wdat[exp_g]);
      end
      if (drop) ch_req = '0;
      hi = 0; done = 0;
      for (int c = 0; c < 20 && !done; c++) begin
        if (c == lat) begin
          ex_mem_ack  = 1'b1;
          ex_mem_rdat = dev_read(ex_mem_adr);
          if (ex_mem_we != '0) dev_mem[int'(ex_mem_adr)] = merge(dev_read(ex_mem_adr), ex_mem_wdat, ex_mem_we);
        end else begin
          ex_mem_rdat = $urandom;
        end
        if (c == 1) prio_mode = ~prio_mode;
        hi++;
        @(negedge bsb_clk);
        ex_mem_ack = 1'b0;
        if (!ex_mem_req) done = 1;
        else begin
          checks++;
          if (ch_ack !== '0 || {ex_mem_we, ex_mem_adr, ex_mem_wdat} !== {f_we[exp_g], f_adr[exp_g], f_wdat[exp_g]}) begin
            errors++; $display("FAIL rnd_hold it=%0d c=%0d got ack=%b adr=%h exp ack=000 adr=%h",
                               it, c, ch_ack, ex_mem_adr, f_adr[exp_g]);
          end
        end
      end
      checks++;
      if (hi != (tmo ? TO_CYC : lat + 1)) begin
        errors++; $display("FAIL rnd_busy_len it=%0d got=%0d exp=%0d", it, hi, tmo ? TO_CYC : lat + 1);
      end
      checks++;
      if (ch_ack !== NCH'(1) << exp_g || ch_err !== (tmo ? NCH'(1) << exp_g : NCH'(0)) ||
          ((tmo || !wr) && ch_rdat !== exp_rd)) begin
        errors++; $display("FAIL rnd_resp it=%0d got ack=%b err=%b rdat=%h exp ch=%0d tmo=%0d rdat=%h",
                           it, ch_ack, ch_err, ch_rdat, exp_g, tmo, exp_rd);
      end
      ch_req = '0;
      @(negedge bsb_clk);
      checks++;
      if (ch_ack !== '0 || ex_mem_req !== 1'b0) begin
        errors++; $display("FAIL rnd_idle it=%0d got ack=%b req=%b exp ack=000 req=0", it, ch_ack, ex_mem_req);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) begin
      f_we[i] = '0; f_adr[i] = '0; f_wdat[i] = '0;
    end
    test_reset();
    test_single_read();
    test_rr_fairness();
    test_fixed_priority();
    test_timeout();
    test_byte_write();
    test_reset_mid_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
